// File: rtl/iir_feeder_pkg.sv
// Shared definitions for the IIR sample feeder: register map, STATUS layout, FSM states.
package iir_feeder_pkg;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_DATA   = 3'd2;
    localparam logic [2:0] REG_FRAMES = 3'd3;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_FLUSH   = 1;
    localparam int CTRL_CLR_OVF = 2;

    localparam int ST_EMPTY = 8;
    localparam int ST_FULL  = 9;
    localparam int ST_BUSY  = 10;
    localparam int ST_OVF   = 11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_GAP  = 2'd2
    } feeder_state_e;

endpackage

// File: rtl/iir_sample_fifo.sv
// Synchronous sample FIFO with flush; a pop makes room for a same-cycle push when full.
module iir_sample_fifo
    import iir_feeder_pkg::*;
#(
    parameter int DW    = 32,
    parameter int DEPTH = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [DW-1:0]              wdata_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [DW-1:0]              rdata_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_LVL = (PW+1)'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   level_q;
    logic          do_push, do_pop;

    assign full_o  = (level_q == FULL_LVL);
    assign empty_o = (level_q == '0);
    assign do_pop  = pop_i & ~empty_o & ~flush_i;
    assign do_push = push_i & ~flush_i & (~full_o | do_pop);
    assign rdata_o = mem_q[rd_ptr_q];
    assign level_o = level_q;

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            level_q <= level_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/iir_sample_feeder.sv
// Bus-loaded sample FIFO that streams whole frames, each followed by a zero gap, to the IIR filter.
module iir_sample_feeder
    import iir_feeder_pkg::*;
#(
    parameter int DW         = 32,
    parameter int AW         = 32,
    parameter int DEPTH      = 64,
    parameter int FRAME_LEN  = 32,
    parameter int GAP_CYCLES = 8
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic [AW-1:0] wb_adr_i,
    input  logic [DW-1:0] wb_dat_i,
    input  logic [3:0]    wb_sel_i,
    input  logic          wb_cyc_i,
    input  logic          wb_stb_i,
    input  logic          wb_we_i,
    output logic [DW-1:0] wb_dat_o,
    output logic          wb_ack_o,
    output logic          wb_err_o,
    output logic          int_o,
    output logic [DW-1:0] sample_o,
    output logic          sample_valid_o,
    output logic          frame_start_o
);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam int IW = $clog2(FRAME_LEN + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    feeder_state_e state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [DW-1:0] sample_q, sample_d, head;
    logic          valid_q, valid_d, start_q, start_d;
    logic          ack_q, en_q, ovf_q, int_q;
    logic [31:0]   frames_q;
    logic [LW-1:0] level;
    logic          full, empty, pop, ready, frame_done;
    logic          wr, wr_ctrl, push, flush;
    logic [2:0]    reg_sel;
    logic          unused_bits;

    assign reg_sel     = wb_adr_i[4:2];
    assign wr          = wb_cyc_i & wb_stb_i & wb_we_i & ~ack_q;
    assign wr_ctrl     = wr & (reg_sel == REG_CTRL);
    assign flush       = wr_ctrl & wb_dat_i[CTRL_FLUSH];
    assign push        = wr & (reg_sel == REG_DATA);
    assign unused_bits = ^{wb_sel_i, wb_adr_i[AW-1:5], wb_adr_i[1:0]};

    iir_sample_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
        .clk_i   (wb_clk_i),
        .rst_i   (wb_rst_i),
        .push_i  (push),
        .wdata_i (wb_dat_i),
        .pop_i   (pop),
        .flush_i (flush),
        .rdata_o (head),
        .level_o (level),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        gap_d      = gap_q;
        pop        = 1'b0;
        sample_d   = '0;
        valid_d    = 1'b0;
        start_d    = 1'b0;
        frame_done = 1'b0;
        ready      = en_q && (level >= LW'(FRAME_LEN));
        case (state_q)
            S_IDLE: if (ready) begin
                state_d = S_RUN;
                idx_d   = '0;
            end
            S_RUN: begin
                pop      = 1'b1;
                sample_d = head;
                valid_d  = 1'b1;
                start_d  = (idx_q == '0);
                if (idx_q == IW'(FRAME_LEN - 1)) begin
                    state_d    = S_GAP;
                    gap_d      = '0;
                    frame_done = 1'b1;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            S_GAP: begin
                // Skip the IDLE dwell when the next frame is ready so frames sit exactly GAP_CYCLES apart.
                if (gap_q == GW'(GAP_CYCLES - 1)) begin
                    state_d = ready ? S_RUN : S_IDLE;
                    idx_d   = '0;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d    = S_IDLE;
            pop        = 1'b0;
            sample_d   = '0;
            valid_d    = 1'b0;
            start_d    = 1'b0;
            frame_done = 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            gap_q    <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            start_q  <= 1'b0;
            ack_q    <= 1'b0;
            en_q     <= 1'b0;
            ovf_q    <= 1'b0;
            int_q    <= 1'b0;
            frames_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            gap_q    <= gap_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            start_q  <= start_d;
            ack_q    <= wb_cyc_i & wb_stb_i & ~ack_q;
            if (wr_ctrl) en_q <= wb_dat_i[CTRL_EN];
            // Set beats clear so an overflow or a finished frame is never lost to a same-cycle clear.
            if (push & full & ~pop)                  ovf_q <= 1'b1;
            else if (wr_ctrl & wb_dat_i[CTRL_CLR_OVF]) ovf_q <= 1'b0;
            if (frame_done)   int_q <= 1'b1;
            else if (wr_ctrl) int_q <= 1'b0;
            if (frame_done) frames_q <= frames_q + 32'd1;
        end
    end

    always_comb begin
        wb_dat_o = '0;
        case (reg_sel)
            REG_CTRL:   wb_dat_o[CTRL_EN] = en_q;
            REG_STATUS: begin
                wb_dat_o[7:0]    = 8'(level);
                wb_dat_o[ST_EMPTY] = empty;
                wb_dat_o[ST_FULL]  = full;
                wb_dat_o[ST_BUSY]  = (state_q != S_IDLE);
                wb_dat_o[ST_OVF]   = ovf_q;
            end
            REG_FRAMES: wb_dat_o = DW'(frames_q);
            default:    wb_dat_o = '0;
        endcase
    end

    assign wb_ack_o       = ack_q;
    assign wb_err_o       = 1'b0;
    assign int_o          = int_q;
    assign sample_o       = sample_q;
    assign sample_valid_o = valid_q;
    assign frame_start_o  = start_q;

endmodule

// File: tb/tb_iir_sample_feeder.sv
// Directed-random bench for iir_sample_feeder against a queue-based model of the frame stream.
module tb_iir_sample_feeder;
    import iir_feeder_pkg::*;

    localparam int FL = 32;
    localparam int GC = 8;
    localparam int DP = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] adr = '0, dat = '0;
    logic [3:0]  sel = 4'hF;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [31:0] wb_dat_o, sample_o;
    logic        wb_ack_o, wb_err_o, int_o, sample_valid_o, frame_start_o;

    int          nchk = 0;
    int          nfail = 0;
    int unsigned mq[$];
    int unsigned m_frames = 0;
    bit          m_ovf = 1'b0;
    bit          m_int = 1'b0;
    logic [31:0] rd;

    always #5 clk = ~clk;

    iir_sample_feeder #(.DW(32), .AW(32), .DEPTH(DP), .FRAME_LEN(FL), .GAP_CYCLES(GC)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat), .wb_sel_i(sel),
        .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
        .wb_err_o(wb_err_o), .int_o(int_o), .sample_o(sample_o), .sample_valid_o(sample_valid_o),
        .frame_start_o(frame_start_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        adr = {27'd0, a, 2'b00}; dat = d; we = 1'b1; cyc = 1'b1; stb = 1'b1;
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        adr = {27'd0, a, 2'b00}; we = 1'b0; cyc = 1'b1; stb = 1'b1;
        @(negedge clk);
        d = wb_dat_o;
        chk("read ack", 64'(wb_ack_o), 64'd1);
        cyc = 1'b0; stb = 1'b0;
    endtask

    task automatic push(input logic [31:0] v);
        bus_wr(REG_DATA, v);
        if (mq.size() < DP) mq.push_back(v);
        else m_ovf = 1'b1;
    endtask

    task automatic ctrl(input logic [31:0] v);
        bus_wr(REG_CTRL, v);
        m_int = 1'b0;
        if (v[1]) mq.delete();
        if (v[2]) m_ovf = 1'b0;
    endtask

    function automatic logic [31:0] st_exp(input bit busy);
        return {20'd0, m_ovf, busy, mq.size() == DP, mq.size() == 0, 8'(mq.size())};
    endfunction

    // One idle cycle, then nframes of FL valid samples each followed by GC zero cycles, then tail zeros.
    task automatic check_stream(input int nframes, input int tail);
        int total;
        total = 1 + nframes * (FL + GC) + tail;
        adr = {27'd0, REG_STATUS, 2'b00};
        for (int c = 0; c < total; c++) begin
            int          k;
            int          pos;
            bit          ev;
            logic [31:0] ed;
            k   = c - 1;
            pos = (k >= 0) ? k % (FL + GC) : -1;
            ev  = (k >= 0) && (k / (FL + GC) < nframes) && (pos < FL);
            ed  = '0;
            @(negedge clk);
            if (ev) ed = mq.pop_front();
            chk($sformatf("stream c%0d", c), 64'({sample_valid_o, frame_start_o, sample_o}),
                64'({ev, ev && pos == 0, ed}));
            if (ev) chk($sformatf("busy c%0d", c), 64'(wb_dat_o[ST_BUSY]), 64'd1);
            chk($sformatf("ovf c%0d", c), 64'(wb_dat_o[ST_OVF]), 64'(m_ovf));
        end
        m_frames += nframes;
        if (nframes > 0) m_int = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // reset state
        chk("rst outs", 64'({sample_valid_o, frame_start_o, sample_o, int_o, wb_ack_o, wb_err_o}), 64'd0);
        bus_rd(REG_STATUS, rd); chk("rst status", 64'(rd), 64'h100);
        bus_rd(REG_FRAMES, rd); chk("rst frames", 64'(rd), 64'd0);
        bus_rd(REG_CTRL, rd);   chk("rst ctrl", 64'(rd), 64'd0);
        bus_rd(3'd5, rd);       chk("unmapped", 64'(rd), 64'd0);

        // 1: samples 1..32 then enable
        for (int i = 1; i <= FL; i++) push(i);
        bus_rd(REG_DATA, rd); chk("data reads 0", 64'(rd), 64'd0);
        ctrl(32'h1);
        check_stream(1, 4);
        chk("t1 int", 64'(int_o), 64'(m_int));
        bus_rd(REG_FRAMES, rd); chk("t1 frames", 64'(rd), 64'(m_frames));

        // 2: one sample short of a frame, then the last one
        for (int i = 0; i < FL - 1; i++) push($urandom);
        ctrl(32'h1);
        chk("t2 int clr", 64'(int_o), 64'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t2 no valid", 64'(sample_valid_o), 64'd0);
        end
        bus_rd(REG_STATUS, rd); chk("t2 status", 64'(rd), 64'(st_exp(1'b0)));
        push($urandom);
        check_stream(1, 2);
        bus_rd(REG_FRAMES, rd); chk("t2 frames", 64'(rd), 64'(m_frames));

        // 3 + 4: fill while disabled, overflow, then clear overflow and enable for two frames
        ctrl(32'h0);
        for (int i = 0; i < DP; i++) push($urandom);
        push(32'hDEAD);
        bus_rd(REG_STATUS, rd); chk("t3 full ovf", 64'(rd), 64'(st_exp(1'b0)));
        ctrl(32'h5);
        check_stream(2, 4);
        bus_rd(REG_FRAMES, rd); chk("t4 frames", 64'(rd), 64'(m_frames));
        chk("t4 int", 64'(int_o), 64'(m_int));
        bus_rd(REG_STATUS, rd); chk("t4 status", 64'(rd), 64'(st_exp(1'b0)));

        // 5: flush mid-frame
        for (int i = 0; i < FL; i++) push($urandom);
        adr = {27'd0, REG_STATUS, 2'b00};
        for (int c = 0; c < 10; c++) begin
            logic [31:0] ed;
            ed = '0;
            @(negedge clk);
            if (c >= 1) ed = mq.pop_front();
            chk($sformatf("t5 pre c%0d", c), 64'({sample_valid_o, frame_start_o, sample_o}),
                64'({c >= 1, c == 1, ed}));
        end
        ctrl(32'h2);
        chk("t5 strobes", 64'({sample_valid_o, frame_start_o, sample_o}), 64'd0);
        bus_rd(REG_STATUS, rd); chk("t5 status", 64'(rd), 64'(st_exp(1'b0)));
        bus_rd(REG_FRAMES, rd); chk("t5 frames", 64'(rd), 64'(m_frames));
        bus_rd(REG_CTRL, rd);   chk("t5 ctrl", 64'(rd), 64'd0);
        chk("t5 int", 64'(int_o), 64'd0);

        // 6: asynchronous reset mid-frame
        ctrl(32'h1);
        for (int i = 0; i < FL; i++) push($urandom);
        repeat (6) @(negedge clk);
        chk("t6 midframe", 64'(sample_valid_o), 64'd1);
        #2 rst = 1'b1;
        #1 chk("t6 async outs", 64'({sample_valid_o, frame_start_o, sample_o, int_o, wb_ack_o}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        mq.delete(); m_frames = 0; m_ovf = 1'b0; m_int = 1'b0;
        bus_rd(REG_STATUS, rd); chk("t6 status", 64'(rd), 64'h100);
        bus_rd(REG_FRAMES, rd); chk("t6 frames", 64'(rd), 64'd0);

        $display("%0d/%0d checks passed", nchk - nfail, nchk);
        $finish;
    end

endmodule
